// File: rtl/store_pkg.sv
// Shared size encodings, FSM state encoding and request legality check for the
// partial-store controller.
package store_pkg;

   localparam logic [1:0] SS_WORD = 2'b00;
   localparam logic [1:0] SS_HALF = 2'b01;
   localparam logic [1:0] SS_BYTE = 2'b10;
   localparam logic [1:0] SS_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } state_t;

   // A request is rejected for the reserved size or a lane offset the size cannot start on.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SS_WORD: bad = (lane != 2'b00);
         SS_HALF: bad = lane[0];
         SS_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Little-endian lane insertion of store data into a read word; purely combinational,
// zero latency, no flow control.
module store_merge
   import store_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   output logic [31:0] merged
);

   always_comb begin
      merged = rdata;
      case (size)
         SS_BYTE: begin
            case (lane)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SS_HALF: begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
         end
         default: merged = rdata;
      endcase
   end

endmodule

// File: rtl/store_size_ctrl.sv
// sw/sh/sb store controller: word stores write directly, byte/half stores read-merge-write.
// Latency: word 2 cycles to done, partial MEM_LAT+3, error 1; start is ignored while busy.
module store_size_ctrl
   import store_pkg::*;
#(
   parameter int MEM_LAT = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  SS_SELETOR,
   input  logic [31:0] addr,
   input  logic [31:0] B_output,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        align_err
);

   state_t      state;
   logic [2:0]  cnt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic [15:0] b_q;
   logic [31:0] merged;

   store_merge u_merge (
      .rdata  (mem_rdata),
      .wdata  (b_q),
      .lane   (lane_q),
      .size   (size_q),
      .merged (merged)
   );

   // mem_wdata doubles as the merge register: it captures the merged word on the last READ cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         lane_q    <= 2'd0;
         size_q    <= 2'd0;
         b_q       <= 16'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         align_err <= 1'b0;
      end else begin
         mem_wr    <= 1'b0;
         done      <= 1'b0;
         align_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lane_q   <= addr[1:0];
                  size_q   <= SS_SELETOR;
                  b_q      <= B_output[15:0];
                  mem_addr <= {addr[31:2], 2'b00};
                  busy     <= 1'b1;
                  if (is_misaligned(SS_SELETOR, addr[1:0])) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     align_err <= 1'b1;
                  end else if (SS_SELETOR == SS_WORD) begin
                     state     <= WRITE;
                     mem_wdata <= B_output;
                     mem_wr    <= 1'b1;
                  end else begin
                     state <= READ;
                     cnt   <= 3'(MEM_LAT);
                  end
               end
            end
            READ: begin
               if (cnt == 3'd0) begin
                  state     <= WRITE;
                  mem_wdata <= merged;
                  mem_wr    <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            WRITE: begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               mem_addr <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_size_ctrl.sv
// Directed bench for store_size_ctrl: one instance at MEM_LAT=1 and one at MEM_LAT=3
// share data inputs; each has its own start.
module tb_store_size_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start1, start3;
   logic [1:0]  SS_SELETOR;
   logic [31:0] addr, B_output, mem_rdata;

   logic [31:0] mem_addr1, mem_wdata1, mem_addr3, mem_wdata3;
   logic        mem_wr1, busy1, done1, err1;
   logic        mem_wr3, busy3, done3, err3;

   logic        cur;
   logic [31:0] o_addr, o_wdata;
   logic        o_wr, o_busy, o_done, o_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   store_size_ctrl #(.MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .SS_SELETOR(SS_SELETOR),
      .addr(addr), .B_output(B_output), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1),
      .busy(busy1), .done(done1), .align_err(err1)
   );

   store_size_ctrl #(.MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .SS_SELETOR(SS_SELETOR),
      .addr(addr), .B_output(B_output), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3),
      .busy(busy3), .done(done3), .align_err(err3)
   );

   assign o_addr  = cur ? mem_addr3  : mem_addr1;
   assign o_wdata = cur ? mem_wdata3 : mem_wdata1;
   assign o_wr    = cur ? mem_wr3    : mem_wr1;
   assign o_busy  = cur ? busy3      : busy1;
   assign o_done  = cur ? done3      : done1;
   assign o_err   = cur ? err3       : err1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"},  {31'd0, o_busy}, 32'd0);
      chk({tag, ".done"},  {31'd0, o_done}, 32'd0);
      chk({tag, ".wr"},    {31'd0, o_wr},   32'd0);
      chk({tag, ".err"},   {31'd0, o_err},  32'd0);
      chk({tag, ".addr"},  o_addr,          32'd0);
   endtask

   // Issues one store from IDLE and walks it to the following IDLE cycle.
   task automatic store(input string tag, input logic d3, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd,
                        input logic [31:0] exp_w, input int lat, input logic err);
      logic [31:0] wa;
      wa  = a & 32'hFFFF_FFFC;
      cur = d3;
      SS_SELETOR = sel; addr = a; B_output = b; mem_rdata = 32'h5A5A_5A5A;
      if (d3) start3 = 1'b1; else start1 = 1'b1;
      tick();
      start1 = 1'b0; start3 = 1'b0;
      SS_SELETOR = ~sel; addr = ~a; B_output = ~b;
      if (err) begin
         chk({tag, ".c1.done"}, {31'd0, o_done}, 32'd1);
         chk({tag, ".c1.err"},  {31'd0, o_err},  32'd1);
         chk({tag, ".c1.wr"},   {31'd0, o_wr},   32'd0);
         chk({tag, ".c1.addr"}, o_addr,          wa);
      end else if (sel == 2'b00) begin
         chk({tag, ".c1.wr"},    {31'd0, o_wr},  32'd1);
         chk({tag, ".c1.wdata"}, o_wdata,        exp_w);
         chk({tag, ".c1.addr"},  o_addr,         wa);
         chk({tag, ".c1.done"},  {31'd0, o_done}, 32'd0);
         tick();
         chk({tag, ".c2.done"}, {31'd0, o_done}, 32'd1);
         chk({tag, ".c2.err"},  {31'd0, o_err},  32'd0);
         chk({tag, ".c2.wr"},   {31'd0, o_wr},   32'd0);
      end else begin
         for (int c = 1; c <= lat + 1; c++) begin
            mem_rdata = (c == lat + 1) ? rd : 32'h5A5A_5A5A;
            chk($sformatf("%s.rd%0d.wr", tag, c),   {31'd0, o_wr},   32'd0);
            chk($sformatf("%s.rd%0d.busy", tag, c), {31'd0, o_busy}, 32'd1);
            chk($sformatf("%s.rd%0d.addr", tag, c), o_addr,          wa);
            tick();
         end
         mem_rdata = 32'hA5A5_A5A5;
         chk({tag, ".wr.wr"},    {31'd0, o_wr}, 32'd1);
         chk({tag, ".wr.wdata"}, o_wdata,       exp_w);
         tick();
         chk({tag, ".dn.done"}, {31'd0, o_done}, 32'd1);
         chk({tag, ".dn.err"},  {31'd0, o_err},  32'd0);
         chk({tag, ".dn.wr"},   {31'd0, o_wr},   32'd0);
         chk({tag, ".dn.addr"}, o_addr,          wa);
      end
      tick();
      chk_idle({tag, ".idle"});
   endtask

   initial begin
      cur = 1'b0;
      reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
      SS_SELETOR = 2'b00; addr = 32'd0; B_output = 32'd0; mem_rdata = 32'd0;
      #2;
      chk_idle("rst1");
      chk("rst1.wdata", mem_wdata1, 32'd0);
      cur = 1'b1;
      chk_idle("rst3");
      cur = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      store("sw",     1'b0, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF, 1, 1'b0);
      store("sb103",  1'b0, 2'b10, 32'h0000_0103, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 1, 1'b0);
      store("sh202",  1'b0, 2'b01, 32'h0000_0202, 32'h0000_CAFE, 32'hFFFF_FFFF, 32'hCAFE_FFFF, 1, 1'b0);
      store("sh200",  1'b0, 2'b01, 32'h0000_0200, 32'h5555_1234, 32'hAABB_CCDD, 32'hAABB_1234, 1, 1'b0);
      store("sb101",  1'b0, 2'b10, 32'h0000_0101, 32'h9988_7777, 32'h0000_0000, 32'h0000_7700, 1, 1'b0);
      store("sh202l3",1'b1, 2'b01, 32'h0000_0202, 32'h0000_CAFE, 32'hFFFF_FFFF, 32'hCAFE_FFFF, 3, 1'b0);
      store("esh201", 1'b0, 2'b01, 32'h0000_0201, 32'h0000_1111, 32'h0,          32'h0,          1, 1'b1);
      store("esw102", 1'b0, 2'b00, 32'h0000_0102, 32'h2222_2222, 32'h0,          32'h0,          1, 1'b1);
      store("ersvd",  1'b0, 2'b11, 32'h0000_0104, 32'h3333_3333, 32'h0,          32'h0,          1, 1'b1);

      // Reset in the middle of a byte store's READ phase.
      cur = 1'b0;
      SS_SELETOR = 2'b10; addr = 32'h0000_0103; B_output = 32'h0000_00AB; mem_rdata = 32'h1122_3344;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("rr.busy", {31'd0, o_busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_idle("rr.async");
      chk("rr.wdata", o_wdata, 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rr.post%0d.wr", i),   {31'd0, o_wr},   32'd0);
         chk($sformatf("rr.post%0d.busy", i), {31'd0, o_busy}, 32'd0);
      end

      // Start pulses while busy must be dropped, not queued.
      SS_SELETOR = 2'b00; addr = 32'h0000_0300; B_output = 32'h0102_0304;
      start1 = 1'b1;
      tick();
      addr = 32'h0000_0400; B_output = 32'hFFFF_0000;
      chk("bz.c1.wr",    {31'd0, o_wr}, 32'd1);
      chk("bz.c1.wdata", o_wdata,       32'h0102_0304);
      tick();
      chk("bz.c2.done", {31'd0, o_done}, 32'd1);
      chk("bz.c2.addr", o_addr,          32'h0000_0300);
      start1 = 1'b0;
      tick();
      chk_idle("bz.idle");
      tick();
      chk_idle("bz.noq");

      store("b2b0", 1'b0, 2'b00, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
      store("b2b1", 1'b0, 2'b00, 32'h0000_0504, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
